sme_loader: RTL and testbench

SME_LOADER -- requirements
Module: sme_loader

---
 rtl/sme_loader.sv | 213 +++++++++++++++++++++
 tb/tb_sme_loader.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sme_loader.sv
`default_nettype none
// ============================================================================
// Module   : sme_loader
// Brief    : Buffers string/pattern characters and launches the SME matcher.
//            Define SME_ANCHOR_PARSE_EN to strip a leading '^' / trailing '$'.
// Revision : 1.0
// ============================================================================
module sme_loader #(
  parameter int STR_DEPTH = 32,
  parameter int PAT_DEPTH = 8
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [7:0]                     chardata,
  input  logic                           isstring,
  input  logic                           ispattern,
  input  logic [$clog2(STR_DEPTH)-1:0]   str_rd_addr,
  output logic [7:0]                     str_rd_data,
  input  logic [$clog2(PAT_DEPTH)-1:0]   pat_rd_addr,
  output logic [7:0]                     pat_rd_data,
  output logic [$clog2(STR_DEPTH+1)-1:0] str_len,
  output logic [$clog2(PAT_DEPTH+1)-1:0] pat_len,
  output logic                           start,
  input  logic                           done,
  output logic                           busy,
  output logic                           err,
  output logic                           head_anchor,
  output logic                           tail_anchor
);

  localparam int SA_W = $clog2(STR_DEPTH);
  localparam int PA_W = $clog2(PAT_DEPTH);
  localparam int SL_W = $clog2(STR_DEPTH + 1);
  localparam int PL_W = $clog2(PAT_DEPTH + 1);

  localparam logic [SL_W-1:0] c_str_max = SL_W'(STR_DEPTH);
  localparam logic [PL_W-1:0] c_pat_max = PL_W'(PAT_DEPTH);
  localparam logic [SL_W-1:0] c_str_one = SL_W'(1);
  localparam logic [PL_W-1:0] c_pat_one = PL_W'(1);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_LOAD_STR = 3'd1,
    S_LOAD_PAT = 3'd2,
    S_ISSUE    = 3'd3,
    S_WAIT     = 3'd4
  } state_t;

  state_t          r_state, w_state_next;
  logic [7:0]      r_str_mem [STR_DEPTH];
  logic [7:0]      r_pat_mem [PAT_DEPTH];
  logic [SL_W-1:0] r_str_len, w_str_len_next;
  logic [PL_W-1:0] r_pat_len, w_pat_len_next;
  logic            r_err, w_err_set;
  logic            w_str_we, w_pat_we, w_pat_first;
  logic [SA_W-1:0] w_str_waddr;
  logic [PA_W-1:0] w_pat_waddr;

`ifdef SME_ANCHOR_PARSE_EN
  localparam logic [7:0] c_caret  = 8'h5E;
  localparam logic [7:0] c_dollar = 8'h24;
  logic            r_head, r_tail, w_head_next, w_tail_next;
  logic [PA_W-1:0] w_pat_last;
  assign w_pat_last = PA_W'(r_pat_len - c_pat_one);
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_next;
  end

  always_comb begin
    w_state_next   = r_state;
    start          = 1'b0;
    busy           = 1'b0;
    w_err_set      = 1'b0;
    w_str_we       = 1'b0;
    w_str_waddr    = r_str_len[SA_W-1:0];
    w_str_len_next = r_str_len;
    w_pat_we       = 1'b0;
    w_pat_waddr    = r_pat_len[PA_W-1:0];
    w_pat_len_next = r_pat_len;
    w_pat_first    = 1'b0;
`ifdef SME_ANCHOR_PARSE_EN
    w_head_next    = r_head;
    w_tail_next    = r_tail;
`endif
    case (r_state)
      S_IDLE: begin
        if (isstring) begin
          w_err_set      = ispattern;
          w_str_we       = 1'b1;
          w_str_waddr    = '0;
          w_str_len_next = c_str_one;
          w_state_next   = S_LOAD_STR;
        end else if (ispattern) begin
          w_pat_first  = 1'b1;
          w_state_next = S_LOAD_PAT;
        end
      end
      S_LOAD_STR: begin
        if (isstring) begin
          w_err_set = ispattern;
          if (r_str_len < c_str_max) begin
            w_str_we       = 1'b1;
            w_str_len_next = r_str_len + c_str_one;
          end else begin
            w_err_set = 1'b1;
          end
        end else if (ispattern) begin
          w_pat_first  = 1'b1;
          w_state_next = S_LOAD_PAT;
        end else begin
          w_state_next = S_IDLE;
        end
      end
      S_LOAD_PAT: begin
        if (ispattern && !isstring) begin
          if (r_pat_len < c_pat_max) begin
            w_pat_we       = 1'b1;
            w_pat_len_next = r_pat_len + c_pat_one;
          end else begin
            w_err_set = 1'b1;
          end
        end else begin
          w_err_set = isstring & ispattern;
          if (r_str_len == '0) begin
            // Nothing to match against: drop the job.
            w_err_set    = 1'b1;
            w_state_next = S_IDLE;
          end else begin
`ifdef SME_ANCHOR_PARSE_EN
            if (r_pat_len != '0 && r_pat_mem[w_pat_last] == c_dollar) begin
              w_pat_len_next = r_pat_len - c_pat_one;
              w_tail_next    = 1'b1;
            end
`endif
            w_state_next = S_ISSUE;
          end
        end
      end
      S_ISSUE: begin
        start        = 1'b1;
        busy         = 1'b1;
        w_err_set    = isstring | ispattern;
        w_state_next = S_WAIT;
      end
      S_WAIT: begin
        busy      = 1'b1;
        w_err_set = isstring | ispattern;
        if (done) w_state_next = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase

    // First pattern character always lands at index 0.
    if (w_pat_first) begin
      w_pat_we       = 1'b1;
      w_pat_waddr    = '0;
      w_pat_len_next = c_pat_one;
`ifdef SME_ANCHOR_PARSE_EN
      w_tail_next = 1'b0;
      w_head_next = (chardata == c_caret);
      if (chardata == c_caret) begin
        w_pat_we       = 1'b0;
        w_pat_len_next = '0;
      end
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (w_str_we) r_str_mem[w_str_waddr] <= chardata;
    if (w_pat_we) r_pat_mem[w_pat_waddr] <= chardata;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_str_len <= '0;
      r_pat_len <= '0;
      r_err     <= 1'b0;
    end else begin
      r_str_len <= w_str_len_next;
      r_pat_len <= w_pat_len_next;
      r_err     <= r_err | w_err_set;
    end
  end

`ifdef SME_ANCHOR_PARSE_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_head <= 1'b0;
      r_tail <= 1'b0;
    end else begin
      r_head <= w_head_next;
      r_tail <= w_tail_next;
    end
  end
  assign head_anchor = r_head;
  assign tail_anchor = r_tail;
`else
  assign head_anchor = 1'b0;
  assign tail_anchor = 1'b0;
`endif

  assign str_rd_data = r_str_mem[str_rd_addr];
  assign pat_rd_data = r_pat_mem[pat_rd_addr];
  assign str_len     = r_str_len;
  assign pat_len     = r_pat_len;
  assign err         = r_err;

endmodule
`default_nettype wire

// File: tb/tb_sme_loader.sv
`default_nettype none
// Testbench for sme_loader: directed jobs against a queue-based reference model.
module tb_sme_loader;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] chardata;
  logic       isstring, ispattern;
  logic [4:0] str_rd_addr;
  logic [7:0] str_rd_data;
  logic [2:0] pat_rd_addr;
  logic [7:0] pat_rd_data;
  logic [5:0] str_len;
  logic [3:0] pat_len;
  logic       start, done, busy, err, head_anchor, tail_anchor;

  always #5 clk = ~clk;

  sme_loader #(.STR_DEPTH(32), .PAT_DEPTH(8)) dut (
    .clk(clk), .reset(reset), .chardata(chardata),
    .isstring(isstring), .ispattern(ispattern),
    .str_rd_addr(str_rd_addr), .str_rd_data(str_rd_data),
    .pat_rd_addr(pat_rd_addr), .pat_rd_data(pat_rd_data),
    .str_len(str_len), .pat_len(pat_len),
    .start(start), .done(done), .busy(busy), .err(err),
    .head_anchor(head_anchor), .tail_anchor(tail_anchor)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: stored characters plus expected flag outputs.
  logic [7:0] q_str[$];
  logic [7:0] q_pat[$];
  logic exp_start = 0, exp_busy = 0, exp_err = 0, exp_head = 0, exp_tail = 0;
  logic cmp_en = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, expv, $time);
    end
  endtask

  always @(negedge clk) begin
    if (cmp_en) begin
      check("cyc start", start, exp_start);
      check("cyc busy", busy, exp_busy);
      check("cyc err", err, exp_err);
      check("cyc str_len", str_len, q_str.size());
      check("cyc pat_len", pat_len, q_pat.size());
      check("cyc head", head_anchor, exp_head);
      check("cyc tail", tail_anchor, exp_tail);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    q_str.delete();
    q_pat.delete();
    exp_start = 0; exp_busy = 0; exp_err = 0; exp_head = 0; exp_tail = 0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    model_reset();
    tick();
    reset = 1'b0;
  endtask

  task automatic send_string(input string s);
    for (int i = 0; i < s.len(); i++) begin
      chardata = s[i]; isstring = 1'b1; ispattern = 1'b0;
      tick();
      if (i == 0) q_str.delete();
      if (q_str.size() < 32) q_str.push_back(s[i]);
      else exp_err = 1'b1;
    end
    isstring = 1'b0; chardata = 8'h00;
  endtask

  // Loads a pattern and runs the cycle in which ispattern is first low.
  task automatic send_pattern(input string p);
    for (int i = 0; i < p.len(); i++) begin
      chardata = p[i]; ispattern = 1'b1; isstring = 1'b0;
      tick();
      if (i == 0) begin
        q_pat.delete();
        exp_head = 1'b0;
        exp_tail = 1'b0;
`ifdef SME_ANCHOR_PARSE_EN
        if (p[i] == 8'h5E) begin
          exp_head = 1'b1;
          continue;
        end
`endif
      end
      if (q_pat.size() < 8) q_pat.push_back(p[i]);
      else exp_err = 1'b1;
    end
    ispattern = 1'b0; chardata = 8'h00;
    tick();
    if (q_str.size() == 0) begin
      exp_err = 1'b1;
    end else begin
`ifdef SME_ANCHOR_PARSE_EN
      if (q_pat.size() > 0 && q_pat[$] == 8'h24) begin
        void'(q_pat.pop_back());
        exp_tail = 1'b1;
      end
`endif
      exp_start = 1'b1;
      exp_busy  = 1'b1;
    end
  endtask

  task automatic finish_job(input int wait_n, input logic poke);
    tick();
    exp_start = 1'b0;
    for (int i = 0; i < wait_n; i++) begin
      if (poke && i == 0) begin isstring = 1'b1; chardata = 8'h7A; end
      tick();
      if (poke && i == 0) begin isstring = 1'b0; chardata = 8'h00; exp_err = 1'b1; end
    end
    done = 1'b1;
    tick();
    done = 1'b0;
    exp_busy = 1'b0;
  endtask

  task automatic check_bufs();
    for (int i = 0; i < q_str.size(); i++) begin
      str_rd_addr = 5'(i);
      #1;
      check("str_buf", str_rd_data, q_str[i]);
    end
    for (int i = 0; i < q_pat.size(); i++) begin
      pat_rd_addr = 3'(i);
      #1;
      check("pat_buf", pat_rd_data, q_pat[i]);
    end
  endtask

  initial begin
    reset = 1'b1; chardata = 8'h00; isstring = 1'b0; ispattern = 1'b0;
    done = 1'b0; str_rd_addr = '0; pat_rd_addr = '0;
    tick(); tick();
    cmp_en = 1'b1;
    check("rst start", start, 0);
    check("rst busy", busy, 0);
    check("rst err", err, 0);
    check("rst str_len", str_len, 0);
    check("rst pat_len", pat_len, 0);
    reset = 1'b0;
    tick();

    // Pattern with no string since reset: rejected, FSM returns to IDLE.
    send_pattern("xy");
    tick();
    check("nostr err", err, 1);
    check("nostr busy", busy, 0);
    check("nostr start", start, 0);
    send_string("k");
    tick();
    check("nostr idle str_len", str_len, 1);
    do_reset();
    tick();

    // "abc" then "b.".
    send_string("abc");
    send_pattern("b.");
    check("abc start latency", start, 1);
    check("abc str_len", str_len, 3);
    check("abc pat_len", pat_len, 2);
    finish_job(3, 1'b0);
    check("abc busy done", busy, 0);
    check_bufs();

    // New pattern only, string kept.
    tick();
    send_pattern("c");
    check("c str_len", str_len, 3);
    check("c pat_len", pat_len, 1);
    check("c start", start, 1);
    check("c err", err, 0);
    finish_job(1, 1'b0);

    // done outside WAIT is ignored.
    done = 1'b1; tick(); tick(); done = 1'b0;
    check("stray done busy", busy, 0);

    // New string after an idle gap replaces the old one.
    send_string("hello");
    tick();
    send_pattern("l*o");
    finish_job(2, 1'b0);
    check_bufs();

    send_string("ab");
    send_pattern("^ab$");
`ifdef SME_ANCHOR_PARSE_EN
    check("anchor pat_len", pat_len, 2);
    check("anchor head", head_anchor, 1);
    check("anchor tail", tail_anchor, 1);
`else
    check("anchor pat_len", pat_len, 4);
    check("anchor head", head_anchor, 0);
    check("anchor tail", tail_anchor, 0);
`endif
    finish_job(1, 1'b0);
    check_bufs();

    // Overflowing string and pattern, plus input poked during WAIT.
    send_string("ABCDEFGHIJKLMNOPQRSTUVWXYZabcdefgh");
    tick();
    check("ovf str_len", str_len, 32);
    check("ovf err", err, 1);
    send_pattern("abcdefghij");
    check("ovf pat_len", pat_len, 8);
    finish_job(2, 1'b1);
    check("poke str_len", str_len, 32);
    check_bufs();

    // isstring and ispattern together in IDLE: string wins.
    chardata = 8'h71; isstring = 1'b1; ispattern = 1'b1;
    tick();
    q_str.delete(); q_str.push_back(8'h71); exp_err = 1'b1;
    isstring = 1'b0; ispattern = 1'b0; chardata = 8'h00;
    check("both str_len", str_len, 1);
    tick();
    send_pattern("q");
    finish_job(1, 1'b0);

    // Reset while waiting for done.
    send_string("xyz");
    send_pattern("y");
    tick();
    exp_start = 1'b0;
    tick();
    #3;
    reset = 1'b1;
    model_reset();
    #1;
    check("wrst busy", busy, 0);
    check("wrst start", start, 0);
    tick();
    reset = 1'b0;
    done = 1'b1;
    tick(); tick();
    done = 1'b0;
    check("wrst late start", start, 0);
    check("wrst late busy", busy, 0);
    tick(); tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
